// File: rtl/rgb_fade_seq_if.sv
// rgb_fade_seq_if: colour command channel (valid/ready).
//   cmd_valid  - command present (master -> slave)
//   cmd_ready  - slave can accept a command (slave -> master)
//   cmd_rgb    - target colour {R,G,B}
//   cmd_fade   - 1 = ramp to target, 0 = jump
//   cmd_blink  - blink enable applied with the command
interface rgb_fade_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_rgb;
  logic        cmd_fade;
  logic        cmd_blink;

  modport master (output cmd_valid, cmd_rgb, cmd_fade, cmd_blink, input cmd_ready);
  modport slave  (input cmd_valid, cmd_rgb, cmd_fade, cmd_blink, output cmd_ready);
endinterface

// File: rtl/rgb_fade_seq.sv
// rgb_fade_seq: colour command stage feeding the RGB PWM driver.
// Commands either jump to a colour or ramp each 8-bit channel one LSB per
// step tick (every STEP_DIV clocks) toward it.
// Ports:
//   clk, n_rst  - clock, async active-low reset
//   cmd         - command channel (slave side)
//   rgb         - current colour, registered
//   blink_en    - blink enable, registered
//   busy        - high while a fade is in progress
//   done        - one-cycle pulse the cycle after a command completes

// One colour channel: next value one LSB toward target, never overshooting.
module rgb_fade_lane #(
  parameter int VEC_W = 8
) (
  input  logic [VEC_W-1:0] cur_i,
  input  logic [VEC_W-1:0] tgt_i,
  output logic [VEC_W-1:0] nxt_o,
  output logic             hit_o
);
  always_comb begin
    nxt_o = cur_i;
    if (cur_i < tgt_i)      nxt_o = cur_i + VEC_W'(1);
    else if (cur_i > tgt_i) nxt_o = cur_i - VEC_W'(1);
  end
  assign hit_o = (nxt_o == tgt_i);
endmodule

module rgb_fade_seq #(
  parameter logic [23:0] STEP_DIV = 24'd105_882
) (
  input  logic                clk,
  input  logic                n_rst,
  rgb_fade_seq_if.slave       cmd,
  output logic [23:0]         rgb,
  output logic                blink_en,
  output logic                busy,
  output logic                done
);
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 8;

  typedef enum logic {IDLE, FADE} state_t;

  state_t                             state_q;
  logic [NUM_LANES-1:0][VEC_W-1:0]    rgb_q, tgt_q, rgb_step_d;
  logic [NUM_LANES-1:0]               lane_hit;
  logic [23:0]                        pre_q;
  logic                               blink_q, busy_q, fin_q, done_q;
  logic                               tick, accept;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rgb_fade_lane #(.VEC_W(VEC_W)) u_lane (
      .cur_i (rgb_q[g]),
      .tgt_i (tgt_q[g]),
      .nxt_o (rgb_step_d[g]),
      .hit_o (lane_hit[g])
    );
  end

  assign cmd.cmd_ready = (state_q == IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign tick          = (pre_q == STEP_DIV - 24'd1);

  // fin_q marks the completing edge; done is that mark delayed one cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      rgb_q   <= '0;
      tgt_q   <= '0;
      pre_q   <= '0;
      blink_q <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fin_q  <= 1'b0;
      done_q <= fin_q;
      case (state_q)
        IDLE: begin
          if (accept) begin
            blink_q <= cmd.cmd_blink;
            tgt_q   <= cmd.cmd_rgb;
            if (!cmd.cmd_fade || (cmd.cmd_rgb == rgb_q)) begin
              rgb_q <= cmd.cmd_rgb;
              fin_q <= 1'b1;
            end else begin
              state_q <= FADE;
              pre_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
        end
        FADE: begin
          if (tick) begin
            pre_q <= '0;
            rgb_q <= rgb_step_d;
            if (&lane_hit) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              fin_q   <= 1'b1;
            end
          end else begin
            pre_q <= pre_q + 24'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rgb      = rgb_q;
  assign blink_en = blink_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_rgb_fade_seq.sv
// tb_rgb_fade_seq: directed + random commands checked against a
// closed-form model (channel after k steps = start moved min(k,|delta|)
// toward target; fade lasts max|delta| * STEP_DIV cycles).
module tb_rgb_fade_seq;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic [23:0] rgb;
  logic        blink_en, busy, done;
  int          total = 0, bad = 0;
  logic [23:0] m_rgb = '0;

  rgb_fade_seq_if cif();

  rgb_fade_seq #(.STEP_DIV(24'(S))) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .cmd      (cif),
    .rgb      (rgb),
    .blink_en (blink_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ramp(input logic [23:0] s, input logic [23:0] t, input int k);
    logic [23:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      int a, b, v;
      a = int'(s[c*8 +: 8]);
      b = int'(t[c*8 +: 8]);
      if (b >= a) v = (b - a <= k) ? b : a + k;
      else        v = (a - b <= k) ? b : a - k;
      r[c*8 +: 8] = 8'(v);
    end
    return r;
  endfunction

  function automatic int max_delta(input logic [23:0] s, input logic [23:0] t);
    int m;
    m = 0;
    for (int c = 0; c < 3; c++) begin
      int a, b, d;
      a = int'(s[c*8 +: 8]);
      b = int'(t[c*8 +: 8]);
      d = (a > b) ? a - b : b - a;
      if (d > m) m = d;
    end
    return m;
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input logic [23:0] c, input logic f, input logic b);
    int n;
    cif.cmd_valid = 1'b1;
    cif.cmd_rgb   = c;
    cif.cmd_fade  = f;
    cif.cmd_blink = b;
    n = 0;
    while (!cif.cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("ready_timeout", cif.cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    cif.cmd_rgb   = 24'($urandom);
    cif.cmd_fade  = 1'($urandom);
    cif.cmd_blink = 1'($urandom);
  endtask

  task automatic cmd_and_check(input logic [23:0] c, input logic f, input logic b);
    logic [23:0] s;
    int d;
    s = m_rgb;
    d = max_delta(s, c);
    send(c, f, b);
    check("blink", blink_en, b);
    if (!f || d == 0) begin
      check("jump_rgb", rgb, c);
      check("jump_busy", busy, 0);
      check("jump_ready", cif.cmd_ready, 1);
      check("jump_done0", done, 0);
      @(negedge clk);
      check("jump_done1", done, 1);
      check("jump_rgb_hold", rgb, c);
    end else begin
      for (int t = 0; t <= d * S; t++) begin
        check("fade_rgb", rgb, ramp(s, c, t / S));
        check("fade_busy", busy, (t < d * S));
        check("fade_ready", cif.cmd_ready, (t >= d * S));
        check("fade_done0", done, 0);
        @(negedge clk);
      end
      check("fade_done1", done, 1);
      check("fade_rgb_end", rgb, c);
    end
    m_rgb = c;
  endtask

  initial begin
    logic [23:0] s, c;
    int d;
    cif.cmd_valid = 1'b0;
    cif.cmd_rgb   = '0;
    cif.cmd_fade  = 1'b0;
    cif.cmd_blink = 1'b0;

    // reset values
    #1 n_rst = 1'b0;
    #1;
    check("rst_rgb", rgb, 24'h000000);
    check("rst_blink", blink_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cif.cmd_ready, 1);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // jump with blink
    cmd_and_check(24'h123456, 1'b0, 1'b1);
    @(negedge clk);
    check("done_single", done, 0);
    cmd_and_check(24'h000000, 1'b0, 1'b0);

    // fades, mixed directions
    cmd_and_check(24'h030000, 1'b1, 1'b0);
    cmd_and_check(24'h000200, 1'b1, 1'b1);

    // jump held valid during a fade
    s = m_rgb;
    c = 24'h040000;
    d = max_delta(s, c);
    send(c, 1'b1, 1'b1);
    cif.cmd_valid = 1'b1;
    cif.cmd_rgb   = 24'hFFFFFF;
    cif.cmd_fade  = 1'b0;
    cif.cmd_blink = 1'b0;
    for (int t = 0; t <= d * S; t++) begin
      check("hold_rgb", rgb, ramp(s, c, t / S));
      check("hold_blink", blink_en, 1);
      check("hold_ready", cif.cmd_ready, (t >= d * S));
      @(negedge clk);
    end
    cif.cmd_valid = 1'b0;
    check("hold_acc_rgb", rgb, 24'hFFFFFF);
    check("hold_acc_blink", blink_en, 0);
    check("hold_fade_done", done, 1);
    @(negedge clk);
    check("hold_jump_done", done, 1);
    @(negedge clk);
    check("hold_done_low", done, 0);
    m_rgb = 24'hFFFFFF;

    // fade to current colour
    cmd_and_check(24'h808080, 1'b0, 1'b0);
    cmd_and_check(24'h808080, 1'b1, 1'b1);

    // random commands
    for (int i = 0; i < 12; i++) begin
      cmd_and_check(24'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // reset mid-fade, pre = 2 after the first step
    cmd_and_check(24'h101010, 1'b0, 1'b1);
    send(24'h202020, 1'b1, 1'b1);
    for (int t = 0; t < S + 2; t++) @(negedge clk);
    check("mid_rgb", rgb, ramp(24'h101010, 24'h202020, 1));
    check("mid_busy", busy, 1);
    #1 n_rst = 1'b0;
    #1;
    check("mrst_rgb", rgb, 24'h000000);
    check("mrst_blink", blink_en, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_ready", cif.cmd_ready, 1);
    @(negedge clk);
    n_rst = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      check("post_rgb", rgb, 24'h000000);
      check("post_busy", busy, 0);
    end
    m_rgb = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rgb_fade_seq.md
# rgb_fade_seq

Colour command stage that sits directly upstream of the RGB LED PWM driver and produces its `rgb[23:0]` and `blink_en` inputs. It accepts colour commands over a valid/ready handshake. Each command either jumps to the new colour at once or ramps each 8-bit channel toward it, one LSB per step tick. Firmware or a sequencer can therefore request smooth crossfades without computing intermediate colours.

## Interface
- `STEP_DIV`, default 24'd105_882: clk cycles per fade step. A full 0→255 ramp takes 255 × 105_882 ≈ 27 000 000 cycles, 1.0 s at 27 MHz. Legal range 1..2^24−1.
- `clk` input 1: system clock, 27 MHz.
- `n_rst` input 1: reset, asynchronous, active-low.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command.
- `cmd_rgb` input 24: target colour; R in [23:16], G in [15:8], B in [7:0].
- `cmd_fade` input 1: 1 = ramp to target, 0 = jump to target.
- `cmd_blink` input 1: blink enable applied with this command.
- `rgb` output 24: current colour, registered; goes to the PWM driver.
- `blink_en` output 1: registered; goes to the PWM driver.
- `busy` output 1: high while a fade is in progress.
- `done` output 1: one-cycle pulse when a command completes.

## Operation
- **States:** IDLE and FADE.
- **`cmd_ready`:** 1 in IDLE, 0 in FADE. Decoded from state only; never from `cmd_valid`.
- **Accept:** a command is accepted on the clk edge where `cmd_valid && cmd_ready`. `cmd_*` is sampled only at that edge, and later changes have no effect.
- **On accept, always:**
  - `blink_en <= cmd_blink`.
  - Target register `tgt <= cmd_rgb`.
- **Jump (`cmd_fade` = 0), or target already equal to `rgb`:**
  - `rgb <= cmd_rgb` on the accept edge.
  - `done` pulses in the following cycle.
  - State stays IDLE.
- **Fade (`cmd_fade` = 1 and `cmd_rgb` ≠ `rgb`):**
  - State → FADE.
  - Prescaler `pre` cleared to 0.
  - `busy` = 1.
- **In FADE:**
  - `pre` increments every cycle.
  - When `pre == STEP_DIV−1`: a step tick fires and `pre` returns to 0.
  - On a step tick, each channel independently: if ch < tgt then ch+1; if ch > tgt then ch−1; else unchanged.
  - Channels never overshoot and never wrap. 8-bit unsigned compares only; no 0↔255 wraparound.
- **Fade completion:**
  - On the step tick where all three channels reach the target: state → IDLE and `busy` → 0 on that same edge.
  - `done` pulses in the next cycle.
- **`cmd_valid` during FADE:** ignored because `cmd_ready` = 0. The upstream must hold the command until `cmd_ready` is 1.
- **Reset** (async assertion, any state, including mid-fade):
  - State = IDLE, `rgb` = 24'h000000, `tgt` = 0, `blink_en` = 0, `busy` = 0, `done` = 0, `pre` = 0.
  - `cmd_ready` = 1 after reset.
  - Any fade in progress is discarded.

## Timing
- **Jump:** accept at edge N; new `rgb` visible after edge N; `done` high during the cycle after edge N+1.
- **Fade:**
  - First step lands at edge N + `STEP_DIV`.
  - Fade of max channel delta D completes at edge N + D × `STEP_DIV`.
  - `done` follows one cycle later.
- **`blink_en`:** changes at the accept edge in both modes.
- **Back-to-back:** `cmd_ready` returns to 1 on the edge completing the fade. A new command can be accepted on the next edge, in the same cycle that `done` is high.
- **Jump sustained throughput:** 1 command per cycle.
- **`STEP_DIV` = 1:** one step per cycle; a fade of delta D takes D cycles.

## Test plan
- **Reset values:** assert `n_rst` → `rgb`=000000, `blink_en`=0, `busy`=0, `done`=0, `cmd_ready`=1.
- **Jump:** `STEP_DIV`=4. Jump to 12_34_56 with `cmd_blink`=1 → `rgb`=123456 and `blink_en`=1 one cycle after accept. Single `done` pulse.
- **Fade, mixed directions:** `STEP_DIV`=4, from 000000, fade to 03_00_00 → R = 1, 2, 3 at accept+4, +8, +12. `busy` falls at +12, `done` at +13. Then fade to 00_02_00 → R falls 3, 2, 1, 0 while G rises 1, 2. Completes after 3 steps (12 cycles).
- **Handshake during fade:** hold `cmd_valid`=1 with a jump to FFFFFF during the fade → not accepted until `cmd_ready` rises. Then accepted; `rgb`=FFFFFF one cycle later.
- **Fade to current colour:** `rgb`=808080, fade to 808080 → no FADE entry, `busy` stays 0, `done` pulses next cycle.
- **Reset mid-fade:** assert `n_rst` mid-fade at `pre`=2 → all outputs return to reset values immediately. After release, no further steps occur.
